// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// bubble insertion and a saturating bubble counter for performance debug.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_alusrc,
  input  logic                  id_memtoreg,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  id_branch,
  input  logic [1:0]            id_aluop,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  ex_alusrc,
  output logic                  ex_memtoreg,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_branch,
  output logic [1:0]            ex_aluop,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rd1,
  output logic [DATA_WIDTH-1:0] ex_rd2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic                  stall,
  output logic [CNT_W-1:0]      bubble_count
);

  logic                  valid_q, alusrc_q, memtoreg_q, regwrite_q;
  logic                  memread_q, memwrite_q, branch_q;
  logic                  valid_d, alusrc_d, memtoreg_d, regwrite_d;
  logic                  memread_d, memwrite_d, branch_d;
  logic [1:0]            aluop_q, aluop_d;
  logic [DATA_WIDTH-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [DATA_WIDTH-1:0] pc_d, rd1_d, rd2_d, imm_d;
  logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [6:0]            funct7_q, funct7_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hazard_c;
  logic                  bubble_c;

  // Conservative load-use check: rs2 is compared even when the consumer ignores it.
  assign hazard_c = valid_q & memread_q & (rd_q != '0) &
                    ((rd_q == id_rs1) | (rd_q == id_rs2)) & id_valid;
  assign bubble_c = flush | hazard_c;
  assign stall    = hazard_c & ~flush;

  always_comb begin
    valid_d    = 1'b0;
    alusrc_d   = 1'b0;
    memtoreg_d = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    branch_d   = 1'b0;
    aluop_d    = 2'b00;
    pc_d       = '0;
    rd1_d      = '0;
    rd2_d      = '0;
    imm_d      = '0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    funct3_d   = '0;
    funct7_d   = '0;
    cnt_d      = cnt_q;
    if (bubble_c) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      // Controls of a non-instruction are masked; datapath fields still load.
      valid_d    = id_valid;
      alusrc_d   = id_alusrc & id_valid;
      memtoreg_d = id_memtoreg & id_valid;
      regwrite_d = id_regwrite & id_valid;
      memread_d  = id_memread & id_valid;
      memwrite_d = id_memwrite & id_valid;
      branch_d   = id_branch & id_valid;
      aluop_d    = id_valid ? id_aluop : 2'b00;
      pc_d       = id_pc;
      rd1_d      = id_rd1;
      rd2_d      = id_rd2;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      funct3_d   = id_funct3;
      funct7_d   = id_funct7;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= 1'b0;
      alusrc_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      branch_q   <= 1'b0;
      aluop_q    <= 2'b00;
      pc_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      alusrc_q   <= alusrc_d;
      memtoreg_q <= memtoreg_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      branch_q   <= branch_d;
      aluop_q    <= aluop_d;
      pc_q       <= pc_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_alusrc    = alusrc_q;
  assign ex_memtoreg  = memtoreg_q;
  assign ex_regwrite  = regwrite_q;
  assign ex_memread   = memread_q;
  assign ex_memwrite  = memwrite_q;
  assign ex_branch    = branch_q;
  assign ex_aluop     = aluop_q;
  assign ex_pc        = pc_q;
  assign ex_rd1       = rd1_q;
  assign ex_rd2       = rd2_q;
  assign ex_imm       = imm_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_funct3    = funct3_q;
  assign ex_funct7    = funct7_q;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/reset scenarios plus random
// traffic, all checked against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned CW     = 4;
  localparam int unsigned CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          id_valid, id_alusrc, id_memtoreg, id_regwrite;
  logic          id_memread, id_memwrite, id_branch;
  logic [1:0]    id_aluop;
  logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]    id_funct3;
  logic [6:0]    id_funct7;
  logic          flush;
  logic          ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite;
  logic          ex_memread, ex_memwrite, ex_branch;
  logic [1:0]    ex_aluop;
  logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0]    ex_funct3;
  logic [6:0]    ex_funct7;
  logic          stall;
  logic [CW-1:0] bubble_count;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_aluop(id_aluop), .id_pc(id_pc), .id_rd1(id_rd1),
    .id_rd2(id_rd2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .flush(flush),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .stall(stall),
    .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          valid, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]    aluop;
    logic [DW-1:0] pc, rd1, rd2, imm;
    logic [AW-1:0] rs1, rs2, rd;
    logic [2:0]    f3;
    logic [6:0]    f7;
  } ex_t;

  ex_t m;
  int  m_cnt;
  int  errors = 0;
  int  checks = 0;
  int  cnt_before;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = '{default: '0};
    m_cnt = 0;
  endtask

  function automatic bit model_hazard();
    return m.valid && m.memread && (m.rd != 0) &&
           ((m.rd == id_rs1) || (m.rd == id_rs2)) && id_valid;
  endfunction

  // One rising edge: a bubble on flush or hazard, otherwise ID moves into EX.
  task automatic model_edge();
    if (flush || model_hazard()) begin
      m = '{default: '0};
      if (m_cnt < CNTMAX) m_cnt = m_cnt + 1;
    end else begin
      m = '{default: '0};
      m.valid = id_valid;
      if (id_valid) begin
        m.alusrc = id_alusrc;   m.memtoreg = id_memtoreg; m.regwrite = id_regwrite;
        m.memread = id_memread; m.memwrite = id_memwrite; m.branch = id_branch;
        m.aluop = id_aluop;
      end
      m.pc = id_pc; m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm;
      m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.f3 = id_funct3; m.f7 = id_funct7;
    end
  endtask

  task automatic check_all();
    chk("ex_valid", ex_valid, m.valid);
    chk("ex_alusrc", ex_alusrc, m.alusrc);
    chk("ex_memtoreg", ex_memtoreg, m.memtoreg);
    chk("ex_regwrite", ex_regwrite, m.regwrite);
    chk("ex_memread", ex_memread, m.memread);
    chk("ex_memwrite", ex_memwrite, m.memwrite);
    chk("ex_branch", ex_branch, m.branch);
    chk("ex_aluop", ex_aluop, m.aluop);
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rd1", ex_rd1, m.rd1);
    chk("ex_rd2", ex_rd2, m.rd2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs1", ex_rs1, m.rs1);
    chk("ex_rs2", ex_rs2, m.rs2);
    chk("ex_rd", ex_rd, m.rd);
    chk("ex_funct3", ex_funct3, m.f3);
    chk("ex_funct7", ex_funct7, m.f7);
    chk("bubble_count", bubble_count, m_cnt);
  endtask

  // Called at a negedge with inputs set; returns at the following negedge.
  task automatic do_cycle();
    #1;
    chk("stall", stall, model_hazard() && !flush);
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_valid = 0; id_alusrc = 0; id_memtoreg = 0; id_regwrite = 0;
    id_memread = 0; id_memwrite = 0; id_branch = 0; id_aluop = 2'b00;
    id_pc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = '0; id_funct7 = '0;
    flush = 0;
  endtask

  task automatic set_rand();
    id_valid = ($urandom_range(0, 3) != 0);
    id_alusrc = 1'($urandom); id_memtoreg = 1'($urandom); id_regwrite = 1'($urandom);
    id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom);
    id_branch = 1'($urandom); id_aluop = 2'($urandom);
    id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
    id_rd = AW'($urandom_range(0, 3));
    id_funct3 = 3'($urandom); id_funct7 = 7'($urandom);
    flush = ($urandom_range(0, 7) == 0);
  endtask

  task automatic set_load(input logic [AW-1:0] rd);
    set_idle();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_memtoreg = 1; id_alusrc = 1;
    id_rd = rd; id_rs1 = 5'd1; id_imm = 32'h10; id_pc = 32'h100;
  endtask

  task automatic set_add(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    set_idle();
    id_valid = 1; id_regwrite = 1; id_aluop = 2'b10;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = 5'd7; id_pc = 32'h104;
  endtask

  initial begin
    set_rand();
    flush = 0;
    model_reset();
    #1 reset = 0;
    // Reset held: random inputs and clock edges must not disturb EX
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_rand();
      @(posedge clk);
      #1;
      chk("rst_stall", stall, 0);
      check_all();
    end
    @(negedge clk);
    set_rand();
    flush = 0;
    reset = 1;
    do_cycle();

    // Plain R-type
    set_idle();
    id_valid = 1; id_regwrite = 1; id_aluop = 2'b10; id_rd = 5'd5;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd1 = 32'h11; id_rd2 = 32'h22;
    cnt_before = m_cnt;
    do_cycle();
    chk("plain_regwrite", ex_regwrite, 1);
    chk("plain_aluop", ex_aluop, 2'b10);
    chk("plain_rd", ex_rd, 5);
    chk("plain_rd1", ex_rd1, 32'h11);
    chk("plain_rd2", ex_rd2, 32'h22);
    chk("plain_stall", stall, 0);

    // Load-use: exactly one stall cycle, one bubble, then the ADD
    cnt_before = m_cnt;
    set_load(5'd6);
    do_cycle();
    set_add(5'd6, 5'd3);
    #1 chk("lu_stall_on", stall, 1);
    do_cycle();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_count", bubble_count, cnt_before + 1);
    #1 chk("lu_stall_off", stall, 0);
    do_cycle();
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 7);
    chk("lu_add_rs1", ex_rs1, 6);

    // x0 destination and non-matching indices never stall
    cnt_before = m_cnt;
    set_load(5'd0);
    do_cycle();
    set_add(5'd0, 5'd0);
    #1 chk("x0_stall", stall, 0);
    do_cycle();
    set_load(5'd7);
    do_cycle();
    set_add(5'd8, 5'd9);
    #1 chk("nomatch_stall", stall, 0);
    do_cycle();
    chk("nostall_count", bubble_count, cnt_before);

    // Flush beats a simultaneous hazard
    set_load(5'd6);
    do_cycle();
    cnt_before = m_cnt;
    set_add(5'd2, 5'd6);
    flush = 1;
    #1 chk("fl_stall", stall, 0);
    do_cycle();
    chk("fl_bubble_valid", ex_valid, 0);
    chk("fl_count", bubble_count, cnt_before + 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_rand();
      do_cycle();
    end

    // Reset asserted mid-stall drops stall immediately
    set_load(5'd4);
    do_cycle();
    set_add(5'd4, 5'd1);
    #1 chk("rs_stall_on", stall, 1);
    #1 reset = 0;
    #1;
    model_reset();
    chk("rs_stall_off", stall, 0);
    chk("rs_valid", ex_valid, 0);
    @(negedge clk);
    reset = 1;

    // Saturation with 20 consecutive flushes, then async reset
    for (int i = 0; i < 20; i++) begin
      set_rand();
      flush = 1;
      do_cycle();
    end
    chk("sat_count", bubble_count, CNTMAX);
    set_rand();
    flush = 1;
    #2 reset = 0;
    #1;
    model_reset();
    chk("sat_async_clear", bubble_count, 0);
    check_all();
    @(negedge clk);
    reset = 1;
    set_idle();
    do_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode (ID) and execute (EX) in the RISC-V pipeline. It captures the decoded control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) together with the operands and register indices, and presents them registered to the EX stage. It contains the load-use hazard detector, which stalls upstream stages and inserts bubbles. It also applies branch flushes and counts inserted bubbles for performance debug.

## Interface
- DATA_WIDTH, 32, width of PC, register operands and immediate
- REG_ADDR_W, 5, register index width
- CNT_W, 16, width of the bubble counter
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoded controls
- id_aluop  in  2  00 LW/SW, 01 branch, 10 R-type, 11 LUI
- id_pc, id_rd1, id_rd2, id_imm  in  DATA_WIDTH  PC, register-file reads, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  REG_ADDR_W  source and destination indices
- id_funct3  in  3 ; id_funct7  in  7  ALU-control fields
- flush  in  1  branch taken in EX; the instruction in ID is squashed
- ex_* (ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7)  out  matching widths  registered copies
- stall  out  1  combinational; IF and IF/ID must hold their contents
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Hazard: hazard = ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2) & id_valid.
- The comparison is deliberately conservative. rs2 is compared even for LW and LUI.
- stall = hazard & ~flush.
- There is no FSM. Each rising edge is one of three mutually exclusive actions, in priority order:
  - FLUSH (flush=1): insert a bubble.
  - STALL (hazard=1): insert a bubble.
  - LOAD (otherwise): all ex_* take the id_* values, and ex_valid takes id_valid.
- Bubble contents:
  - ex_valid, ex_regwrite, ex_memread, ex_memwrite and ex_branch are forced to 0, and ex_aluop to 00.
  - Datapath fields (pc, rd1, rd2, imm, rs1, rs2, rd, funct*) are also cleared to 0. This gives deterministic waveforms.
- If id_valid=0 in a LOAD cycle, all control outputs are masked to 0 regardless of the id_* control inputs. Datapath fields still load.
- bubble_count:
  - Increments by 1 on every FLUSH or STALL edge.
  - Holds at 2^CNT_W−1; no wrap.
  - LOAD edges with id_valid=0 do not count.
- Only reset clears bubble_count. flush and stall do not.

## Timing
- Reset asserted (low): every ex_* output and bubble_count go to 0 immediately, without waiting for clk. stall=0 because ex_valid=0.
- Reset released: first capture on the next rising edge.
- Latency: id_* to ex_* is 1 cycle.
- stall depends combinationally on the current ex_* registers and the id_* inputs. It is valid within the same cycle.
- A load-use pair gives exactly one stall cycle:
  - Cycle N: stall=1 and a bubble is inserted.
  - Cycle N+1: ex_memread=0, so stall=0 and the held instruction loads.
- flush and hazard in the same cycle: flush wins, stall=0, and one bubble is counted.
- Reset asserted mid-stall: stall drops the same cycle, because ex_valid clears asynchronously.
- Back-to-back loads to the same rd: each dependent consumer produces its own single stall.

## Test plan
- Reset: hold reset=0 with random id_* and toggle clk. Required: all ex_*=0, stall=0, bubble_count=0. Release reset; the next edge loads id_*.
- Plain pipeline: R-type (regwrite=1, aluop=10, rd=5, rd1=0x11, rd2=0x22). Required one cycle later: ex_regwrite=1, ex_aluop=10, ex_rd=5, ex_rd1=0x11, ex_rd2=0x22, stall=0.
- Load-use: LW x6 followed by ADD with rs1=6. Required:
  - stall=1 for exactly one cycle.
  - The next EX contents are a bubble (ex_valid=0).
  - The cycle after, the ADD appears in EX.
  - bubble_count=1.
- x0 and non-match: LW with rd=0, then a consumer with rs1=0. Separately, LW rd=7 then consumer rs1=8, rs2=9. Required: stall never asserts.
- Flush priority: a load-use hazard plus flush=1 in the same cycle. Required: stall=0, a bubble is inserted, and bubble_count increments by exactly 1.
- Saturation: CNT_W=4 with 20 consecutive flush cycles. Required: bubble_count stops at 15. An async reset mid-sequence returns it to 0 immediately.
